// File: rtl/rvfi_pkg.sv
// Shared retirement-record types for the RVFI reorder buffer.
// Data fields are sized for the widest supported XLEN (64); narrower
// configurations zero-extend on the way in and slice on the way out.
package rvfi_pkg;

   localparam int ORDER_W  = 8;
   localparam int XLEN_MAX = 64;

   typedef struct packed {
      logic [ORDER_W-1:0]  order;
      logic [31:0]         insn;
      logic [4:0]          rs1_addr;
      logic [4:0]          rs2_addr;
      logic [4:0]          rd;
      logic [XLEN_MAX-1:0] rs1_rdata;
      logic [XLEN_MAX-1:0] rs2_rdata;
      logic [XLEN_MAX-1:0] post_rd;
      logic                trap;
   } rvfi_rec_t;

endpackage

// File: rtl/rvfi_reorder_slots.sv
// DEPTH-entry record store with per-slot occupied bits.
// One write port (sets occupied) and one read/clear port (head slot).
// A write and a clear to the same slot in one cycle leaves it occupied.
module rvfi_reorder_slots
   import rvfi_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
   input  rvfi_rec_t                i_wr_data,
   output logic                     o_wr_occ,
   input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
   input  logic                     i_clr_en,
   output logic                     o_rd_occ,
   output rvfi_rec_t                o_rd_data
);

   logic [DEPTH-1:0] r_occ;
   rvfi_rec_t        r_mem [DEPTH];

   // Occupied bits: clear on emit, then set on write so write wins on a shared slot
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_occ <= '0;
      end else begin
         if (i_clr_en) r_occ[i_rd_idx] <= 1'b0;
         if (i_wr_en)  r_occ[i_wr_idx] <= 1'b1;
      end
   end

   // Record storage; contents are only meaningful where occupied is set
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
   end

   assign o_wr_occ  = r_occ[i_wr_idx];
   assign o_rd_occ  = r_occ[i_rd_idx];
   assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/rvfi_reorder.sv
// Reorders out-of-order RVFI retirement records into strict in_order
// sequence (mod 256). Records are slotted by in_order mod DEPTH and the
// head slot is emitted through a registered output stage.
// Optional: define RVFI_REORDER_ERR_EN to add the sticky err output
// (duplicate record, or 256 consecutive stalled offers).
// XLEN must be <= 64.
module rvfi_reorder
   import rvfi_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_order,
   input  logic [31:0]        in_insn,
   input  logic [4:0]         in_rs1_addr,
   input  logic [4:0]         in_rs2_addr,
   input  logic [4:0]         in_rd,
   input  logic [XLEN-1:0]    in_rs1_rdata,
   input  logic [XLEN-1:0]    in_rs2_rdata,
   input  logic [XLEN-1:0]    in_post_rd,
   input  logic               in_trap,
   output logic               out_valid,
   output logic [7:0]         out_order,
   output logic [31:0]        out_insn,
   output logic [4:0]         out_rs1_addr,
   output logic [4:0]         out_rs2_addr,
   output logic [4:0]         out_rd,
   output logic [XLEN-1:0]    out_rs1_rdata,
   output logic [XLEN-1:0]    out_rs2_rdata,
   output logic [XLEN-1:0]    out_post_rd,
   output logic               out_trap
`ifdef RVFI_REORDER_ERR_EN
   ,output logic              err
`endif
);

   localparam int                 IW      = $clog2(DEPTH);
   localparam logic [ORDER_W-1:0] DEPTH_W = ORDER_W'(DEPTH);

   logic [ORDER_W-1:0] r_exp;
   logic               r_out_valid;
   rvfi_rec_t          r_out;

   logic [ORDER_W-1:0] w_dist;
   logic [IW-1:0]      w_head;
   logic [IW-1:0]      w_wr_idx;
   logic               w_acc;
   logic               w_wr_en;
   logic               w_wr_occ;
   logic               w_freeing;
   logic               w_emit;
   rvfi_rec_t          w_wr_rec;
   rvfi_rec_t          w_rd_rec;

   // Window: only orders exp .. exp+DEPTH-1 have a free slot of their own
   assign w_dist    = in_order - r_exp;
   assign in_ready  = resetn & (w_dist < DEPTH_W);
   assign w_acc     = in_valid & in_ready;
   assign w_head    = r_exp[IW-1:0];
   assign w_wr_idx  = in_order[IW-1:0];
   assign w_freeing = w_emit & (w_wr_idx == w_head);
   // An occupied target that is not draining this cycle means a duplicate: drop it
   assign w_wr_en   = w_acc & (~w_wr_occ | w_freeing);

   // Pack the incoming fields, zero-extending data to the stored width
   always_comb begin
      w_wr_rec                      = '0;
      w_wr_rec.order                = in_order;
      w_wr_rec.insn                 = in_insn;
      w_wr_rec.rs1_addr             = in_rs1_addr;
      w_wr_rec.rs2_addr             = in_rs2_addr;
      w_wr_rec.rd                   = in_rd;
      w_wr_rec.rs1_rdata[XLEN-1:0]  = in_rs1_rdata;
      w_wr_rec.rs2_rdata[XLEN-1:0]  = in_rs2_rdata;
      w_wr_rec.post_rd[XLEN-1:0]    = in_post_rd;
      w_wr_rec.trap                 = in_trap;
   end

   rvfi_reorder_slots #(.DEPTH(DEPTH)) u_slots (
      .clk       (clk),
      .resetn    (resetn),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_wr_idx),
      .i_wr_data (w_wr_rec),
      .o_wr_occ  (w_wr_occ),
      .i_rd_idx  (w_head),
      .i_clr_en  (w_emit),
      .o_rd_occ  (w_emit),
      .o_rd_data (w_rd_rec)
   );

   // Emit the head record through the output register and advance exp
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_exp       <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_emit) begin
         r_exp       <= r_exp + 1'b1;
         r_out_valid <= 1'b1;
         r_out       <= w_rd_rec;
      end else begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid     = r_out_valid;
   assign out_order     = r_out.order;
   assign out_insn      = r_out.insn;
   assign out_rs1_addr  = r_out.rs1_addr;
   assign out_rs2_addr  = r_out.rs2_addr;
   assign out_rd        = r_out.rd;
   assign out_rs1_rdata = r_out.rs1_rdata[XLEN-1:0];
   assign out_rs2_rdata = r_out.rs2_rdata[XLEN-1:0];
   assign out_post_rd   = r_out.post_rd[XLEN-1:0];
   assign out_trap      = r_out.trap;

   // Upper data bits are always zero for narrow XLEN
   generate
      if (XLEN < XLEN_MAX) begin : g_hi
         logic w_unused_hi;
         assign w_unused_hi = ^{r_out.rs1_rdata[XLEN_MAX-1:XLEN],
                                r_out.rs2_rdata[XLEN_MAX-1:XLEN],
                                r_out.post_rd[XLEN_MAX-1:XLEN]};
      end
   endgenerate

`ifdef RVFI_REORDER_ERR_EN
   logic               r_err;
   logic [ORDER_W-1:0] r_stall_cnt;
   logic               w_dup;
   logic               w_stall;

   assign w_dup   = w_acc & w_wr_occ & ~w_freeing;
   assign w_stall = in_valid & ~in_ready;

   // Sticky error: duplicate drop, or the 256th consecutive stalled offer
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_err       <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         if (w_dup) r_err <= 1'b1;
         if (w_stall) begin
            if (&r_stall_cnt) r_err       <= 1'b1;
            else              r_stall_cnt <= r_stall_cnt + 1'b1;
         end else begin
            r_stall_cnt <= '0;
         end
      end
   end

   assign err = r_err;
`endif

endmodule

// File: tb/tb_rvfi_reorder.sv
// Directed bench for rvfi_reorder (XLEN=32, DEPTH=8). Record fields are
// derived from the order number so each emitted record can be checked whole.
module tb_rvfi_reorder;

   localparam int REC_W = 152;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_order = '0;
   logic [31:0] in_insn = '0;
   logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd = '0;
   logic [31:0] in_rs1_rdata = '0, in_rs2_rdata = '0, in_post_rd = '0;
   logic        in_trap = 1'b0;
   logic        out_valid;
   logic [7:0]  out_order;
   logic [31:0] out_insn;
   logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd;
   logic [31:0] out_rs1_rdata, out_rs2_rdata, out_post_rd;
   logic        out_trap;
`ifdef RVFI_REORDER_ERR_EN
   logic        err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   rvfi_reorder #(.XLEN(32), .DEPTH(8)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_order      (in_order),
      .in_insn       (in_insn),
      .in_rs1_addr   (in_rs1_addr),
      .in_rs2_addr   (in_rs2_addr),
      .in_rd         (in_rd),
      .in_rs1_rdata  (in_rs1_rdata),
      .in_rs2_rdata  (in_rs2_rdata),
      .in_post_rd    (in_post_rd),
      .in_trap       (in_trap),
      .out_valid     (out_valid),
      .out_order     (out_order),
      .out_insn      (out_insn),
      .out_rs1_addr  (out_rs1_addr),
      .out_rs2_addr  (out_rs2_addr),
      .out_rd        (out_rd),
      .out_rs1_rdata (out_rs1_rdata),
      .out_rs2_rdata (out_rs2_rdata),
      .out_post_rd   (out_post_rd),
      .out_trap      (out_trap)
`ifdef RVFI_REORDER_ERR_EN
      ,.err          (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [REC_W-1:0] act,
                        input logic [REC_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Expected record for a given order; bad=1 gives a distinguishable copy
   function automatic logic [REC_W-1:0] exp_rec(input logic [7:0] o, input logic bad);
      logic [31:0] post;
      post = 32'h3000_0000 | {24'h0, o};
      if (bad) post = post ^ 32'hFFFF_0000;
      return {o, {24'h13A5C3, o}, o[4:0], ~o[4:0], o[4:0] + 5'd1,
              32'h1000_0000 | {24'h0, o}, 32'h2000_0000 | {24'h0, o}, post, o[0]};
   endfunction

   function automatic logic [REC_W-1:0] act_rec();
      return {out_order, out_insn, out_rs1_addr, out_rs2_addr, out_rd,
              out_rs1_rdata, out_rs2_rdata, out_post_rd, out_trap};
   endfunction

   task automatic drive(input logic [7:0] o, input logic bad);
      logic [REC_W-1:0] r;
      r = exp_rec(o, bad);
      in_valid = 1'b1;
      {in_order, in_insn, in_rs1_addr, in_rs2_addr, in_rd,
       in_rs1_rdata, in_rs2_rdata, in_post_rd, in_trap} = r;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] o);
      check({tag, "_v"}, out_valid, 1);
      check({tag, "_rec"}, act_rec(), exp_rec(o, 1'b0));
   endtask

   // In-order stream of n records starting at 'first'; one emit per cycle, 2-cycle latency
   task automatic stream(input int first, input int n, input string tag);
      for (int i = 0; i <= n; i++) begin
         if (i < n) begin
            drive(8'((first + i) % 256), 1'b0);
            #1 check({tag, "_rdy"}, in_ready, 1);
         end else begin
            idle();
         end
         step();
         if (i == 0) check({tag, "_lat"}, out_valid, 0);
         else        chk_out(tag, 8'((first + i - 1) % 256));
      end
      step();
      check({tag, "_end_v"}, out_valid, 0);
      check({tag, "_hold"}, out_order, 8'((first + n - 1) % 256));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state; in_ready held low while resetn is low
      resetn = 1'b0;
      drive(8'd0, 1'b0);
      step();
      check("rst_rdy", in_ready, 0);
      check("rst_v", out_valid, 0);
      check("rst_rec", act_rec(), '0);
`ifdef RVFI_REORDER_ERR_EN
      check("rst_err", err, 0);
`endif
      idle();
      resetn = 1'b1;
      step();

      // In-order 0..3
      stream(0, 4, "inord");

      // Reversed 3,2,1,0: nothing until 0 lands, then 0..3 back to back
      do_reset();
      for (int k = 3; k >= 0; k--) begin
         drive(8'(k), 1'b0);
         step();
         check("rev_wait", out_valid, 0);
      end
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out("rev", 8'(k));
      end
      step();
      check("rev_end_v", out_valid, 0);

      // Window: order 8 stalls until 0 has been emitted
      do_reset();
      drive(8'd0, 1'b0);
      step();
      drive(8'd8, 1'b0);
      #1 check("win_stall", in_ready, 0);
      step();
      chk_out("win_o0", 8'd0);
      check("win_open", in_ready, 1);
      step();
      check("win_gap", out_valid, 0);
      for (int k = 1; k <= 7; k++) begin
         drive(8'(k), 1'b0);
         step();
         if (k == 1) check("win_w1", out_valid, 0);
         else        chk_out("win", 8'(k - 1));
      end
      idle();
      step();
      chk_out("win", 8'd7);
      step();
      chk_out("win_o8", 8'd8);
      step();
      check("win_end_v", out_valid, 0);

      // Wrap: 0..255 then 0..5, gap-free across 255 -> 0
      do_reset();
      stream(0, 262, "wrap");

      // Duplicate order 4 while exp=0: first copy kept
      do_reset();
      drive(8'd4, 1'b0);
      step();
`ifdef RVFI_REORDER_ERR_EN
      check("dup_err0", err, 0);
`endif
      drive(8'd4, 1'b1);
      #1 check("dup_rdy", in_ready, 1);
      step();
`ifdef RVFI_REORDER_ERR_EN
      check("dup_err1", err, 1);
`endif
      for (int k = 0; k < 4; k++) begin
         drive(8'(k), 1'b0);
         step();
         if (k == 0) check("dup_w0", out_valid, 0);
         else        chk_out("dup", 8'(k - 1));
      end
      idle();
      step();
      chk_out("dup", 8'd3);
      step();
      chk_out("dup_kept", 8'd4);
      step();
      check("dup_end_v", out_valid, 0);
`ifdef RVFI_REORDER_ERR_EN
      check("dup_sticky", err, 1);
`endif

      // Reset mid-operation with 1,2 buffered: both discarded
      do_reset();
      drive(8'd1, 1'b0);
      step();
      drive(8'd2, 1'b0);
      step();
      idle();
      resetn = 1'b0;
      #1 check("mrst_rdy", in_ready, 0);
      step();
      check("mrst_v", out_valid, 0);
      check("mrst_rec", act_rec(), '0);
      resetn = 1'b1;
      drive(8'd1, 1'b0);
      #1 check("mrst_rdy1", in_ready, 1);
      step();
      check("mrst_w1", out_valid, 0);
      drive(8'd0, 1'b0);
      step();
      check("mrst_w0", out_valid, 0);
      idle();
      step();
      chk_out("mrst", 8'd0);
      step();
      chk_out("mrst", 8'd1);
      step();
      check("mrst_no2", out_valid, 0);

`ifdef RVFI_REORDER_ERR_EN
      // Stall timeout: order 8 at exp=0 offered for 256 cycles
      do_reset();
      check("stall_err_clr", err, 0);
      drive(8'd8, 1'b0);
      repeat (255) step();
      check("stall_255", err, 0);
      step();
      check("stall_256", err, 1);
      idle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
